// File: rtl/lfsr_pkg.sv
// Shared LFSR types, default maximal tap masks and the Fibonacci step function.
package lfsr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   // Tap masks: bit i set feeds state[i] into the XOR (polynomial minus its leading term).
   localparam logic [7:0]  TAPS_W8  = 8'h1D;         // x^8+x^4+x^3+x^2+1
   localparam logic [15:0] TAPS_W16 = 16'h6801;      // x^16+x^14+x^13+x^11+1
   localparam logic [31:0] TAPS_W32 = 32'h0040_0007; // x^32+x^22+x^2+x+1

   // Shift right by one; parity of the tapped bits enters at bit width-1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int          width);
      logic [31:0] fb_vec;
      fb_vec = {31'b0, ^(state & taps)};
      return (state >> 1) | (fb_vec << (width - 1));
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Purely combinational Fibonacci LFSR next-state for any width up to 32.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] taps,
   output logic [WIDTH-1:0] next
);

   always_comb begin
      next = WIDTH'(lfsr_next(32'(state), 32'(taps), WIDTH));
   end

endmodule

// File: rtl/lfsr_stream.sv
// LFSR pseudo-random source with valid/ready output, seed load, lock-up recovery
// and full-period wrap pulse. Define LFSR_CHECK_EN to add the sticky period_err output.
module lfsr_stream
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
   parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             lockup
`ifdef LFSR_CHECK_EN
   ,
   output logic             period_err
`endif
);

   // Counter value at which the next accepted handshake closes a 2^WIDTH-1 period.
   localparam logic [WIDTH-1:0] WRAP_AT = {{(WIDTH-1){1'b1}}, 1'b0};

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;
   logic [WIDTH-1:0] step_val;
   logic             handshake;
`ifdef LFSR_CHECK_EN
   logic [WIDTH-1:0] start_q, start_d;
   logic             err_q, err_d;
`endif

   lfsr_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .state (state_q),
      .taps  (TAPS),
      .next  (step_val)
   );

   assign out_valid = (fsm_q == RUN);
   assign out       = state_q;
   assign wrap      = wrap_q;
   assign lockup    = lockup_q;
   assign handshake = out_valid && out_ready;
`ifdef LFSR_CHECK_EN
   assign period_err = err_q;
`endif

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;
`ifdef LFSR_CHECK_EN
      start_d  = start_q;
      err_d    = err_q;
`endif

      case (fsm_q)
         IDLE:    if (en && !load) fsm_d = RUN;
         RUN:     if (!en) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase

      if (load) begin
         fsm_d = IDLE;
         cnt_d = '0;
         if (seed == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
         end else begin
            state_d = seed;
         end
`ifdef LFSR_CHECK_EN
         start_d = state_d;
         err_d   = 1'b0;
`endif
      end else if (state_q == '0) begin
         // All-zero is a fixed point of the step; only corruption or bad taps get here.
         state_d  = SEED;
         lockup_d = 1'b1;
      end else if (handshake) begin
         state_d = step_val;
         if (cnt_q == WRAP_AT) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
`ifdef LFSR_CHECK_EN
            if (step_val != start_q) err_d = 1'b1;
`endif
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q    <= IDLE;
         state_q  <= SEED;
         cnt_q    <= '0;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
`ifdef LFSR_CHECK_EN
         start_q  <= SEED;
         err_q    <= 1'b0;
`endif
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
`ifdef LFSR_CHECK_EN
         start_q  <= start_d;
         err_q    <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: directed vector table, full-period run and
// randomized traffic against a reference model. LFSR_CHECK_EN adds a non-maximal-taps instance.
module tb_lfsr_stream;

   logic       clk = 1'b0;
   logic       rst, en, load, out_ready;
   logic [7:0] seed;
   logic       out_valid, wrap, lockup;
   logic [7:0] out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

`ifdef LFSR_CHECK_EN
   logic       period_err;
   logic       en2, load2, ready2;
   logic [7:0] seed2;
   logic       valid2, wrap2, lockup2, period_err2;
   logic [7:0] out2;
`endif

   lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .seed      (seed),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out       (out),
      .wrap      (wrap),
      .lockup    (lockup)
`ifdef LFSR_CHECK_EN
      ,
      .period_err(period_err)
`endif
   );

`ifdef LFSR_CHECK_EN
   lfsr_stream #(.WIDTH(8), .TAPS(8'h03), .SEED(8'h01)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .en        (en2),
      .load      (load2),
      .seed      (seed2),
      .out_ready (ready2),
      .out_valid (valid2),
      .out       (out2),
      .wrap      (wrap2),
      .lockup    (lockup2),
      .period_err(period_err2)
   );
`endif

   // Reference model: sequence position tracked as a plain accept count.
   int m_state, m_start, m_accepts;
   bit m_valid, m_wrap, m_lock, m_err;

   function automatic int ref_step(input int s, input int taps);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++)
         if ((((s >> i) & 1) == 1) && (((taps >> i) & 1) == 1)) p = p ^ 1;
      return (s / 2) + p * 128;
   endfunction

   task automatic model_update();
      bit hs;
      hs = m_valid && out_ready;
      m_wrap = 0;
      m_lock = 0;
      if (rst) begin
         m_state = 1; m_start = 1; m_accepts = 0; m_valid = 0; m_err = 0;
      end else if (load) begin
         m_valid = 0;
         m_accepts = 0;
         if (seed == 8'h00) begin
            m_state = 1;
            m_lock = 1;
         end else begin
            m_state = int'(seed);
         end
         m_start = m_state;
         m_err = 0;
      end else begin
         if (hs) begin
            m_state = ref_step(m_state, 'h1D);
            m_accepts++;
            if (m_accepts % 255 == 0) begin
               m_wrap = 1;
               if (m_state != m_start) m_err = 1;
            end
         end
         m_valid = en;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag);
      model_update();
      tick();
      chk({tag, ".out"}, 32'(out), 32'(m_state));
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
      chk({tag, ".lockup"}, 32'(lockup), 32'(m_lock));
`ifdef LFSR_CHECK_EN
      chk({tag, ".period_err"}, 32'(period_err), 32'(m_err));
`endif
   endtask

   typedef struct {
      logic       en;
      logic       load;
      logic [7:0] seed;
      logic       rdy;
      logic [7:0] x_out;
      logic       x_valid;
      logic       x_wrap;
      logic       x_lock;
   } vec_t;

   vec_t vec[17];
   int   wraps;

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; seed = 8'h00; out_ready = 1'b0;
`ifdef LFSR_CHECK_EN
      en2 = 1'b0; load2 = 1'b0; seed2 = 8'h01; ready2 = 1'b0;
`endif

      // Stream, backpressure at 40, load A5 while running, then zero-seed load.
      vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
      vec[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
      vec[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0};
      vec[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
      vec[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
      vec[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
      vec[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
      vec[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
      vec[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0};
      vec[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0};
      vec[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0};
      vec[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hC4, 1'b1, 1'b0, 1'b0};
      vec[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hE2, 1'b1, 1'b0, 1'b0};
      vec[13] = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vec[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      vec[15] = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
      vec[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

      // Reset defaults after two reset cycles.
      tick();
      tick();
      chk("reset.out", 32'(out), 32'h01);
      chk("reset.valid", 32'(out_valid), 32'h0);
      chk("reset.wrap", 32'(wrap), 32'h0);
      chk("reset.lockup", 32'(lockup), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         en = vec[i].en; load = vec[i].load; seed = vec[i].seed; out_ready = vec[i].rdy;
         tick();
         $display("vec %0d: en=%0b load=%0b seed=%02h rdy=%0b -> out=%02h valid=%0b wrap=%0b lockup=%0b",
                  i, en, load, seed, out_ready, out, out_valid, wrap, lockup);
         chk($sformatf("vec%0d.out", i), 32'(out), 32'(vec[i].x_out));
         chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vec[i].x_valid));
         chk($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vec[i].x_wrap));
         chk($sformatf("vec%0d.lockup", i), 32'(lockup), 32'(vec[i].x_lock));
      end

      // Full period: wrap exactly at accepts 255 and 510, never at 254.
      rst = 1'b1; load = 1'b0; en = 1'b0; out_ready = 1'b1;
      step_chk("prd_rst");
      rst = 1'b0; en = 1'b1;
      step_chk("prd_start");
      wraps = 0;
      for (int k = 1; k <= 510; k++) begin
         step_chk("prd");
         if (wrap) wraps++;
         if (k == 254) chk("prd.no_wrap_254", 32'(wrap), 32'h0);
         if (k == 255 || k == 510) begin
            chk($sformatf("prd.wrap_%0d", k), 32'(wrap), 32'h1);
            chk($sformatf("prd.out_%0d", k), 32'(out), 32'h01);
         end
      end
      chk("prd.wrap_count", 32'(wraps), 32'd2);
      $display("period run: 510 accepts, %0d wrap pulses", wraps);

      // Randomized traffic, including zero seeds and mid-stream reset.
      for (int c = 0; c < 1500; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 9) != 0);
         load      = ($urandom_range(0, 39) == 0);
         seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         step_chk("rnd");
         $display("rnd %0d: rst=%0b en=%0b load=%0b seed=%02h rdy=%0b -> out=%02h valid=%0b wrap=%0b lockup=%0b",
                  c, rst, en, load, seed, out_ready, out, out_valid, wrap, lockup);
      end

`ifdef LFSR_CHECK_EN
      // Non-maximal taps: period_err sets on the first wrap and holds until load.
      rst = 1'b1; en = 1'b0; load = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0; en2 = 1'b1; ready2 = 1'b1;
      tick();
      for (int k = 1; k <= 255; k++) begin
         tick();
         if (k == 254) chk("chk.err_before_wrap", 32'(period_err2), 32'h0);
      end
      chk("chk.wrap2", 32'(wrap2), 32'h1);
      chk("chk.err_set", 32'(period_err2), 32'h1);
      for (int k = 0; k < 20; k++) tick();
      chk("chk.err_sticky", 32'(period_err2), 32'h1);
      load2 = 1'b1; seed2 = 8'h01;
      tick();
      load2 = 1'b0;
      chk("chk.err_cleared", 32'(period_err2), 32'h0);
      $display("period check: non-maximal taps flagged and cleared by load");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
